// File: rtl/read_bpm_test_link.sv
// Receive end of the BPM test link. Parses header + data-word packets arriving
// on the Aurora user clock, checks magic and length, publishes good packets
// with a one-cycle strobe and keeps per-FA-cycle and error statistics.
module read_bpm_test_link #(
    parameter int                     MAGIC_WIDTH     = 16,
    parameter int                     MAGIC_START_BIT = 16,
    parameter int                     INDEX_WIDTH     = 5,
    parameter int                     INDEX_START_BIT = 10,
    parameter int                     NUM_DATA_WORDS  = 3,
    parameter logic [MAGIC_WIDTH-1:0] EXPECTED_MAGIC  = 16'hA5BE,
    parameter int                     COUNT_WIDTH     = 8
) (
    input  logic                         auroraUserClk,
    input  logic                         auroraResetN,
    input  logic                         auroraChannelUp,
    input  logic                         auroraFAstrobe,
    input  logic [31:0]                  BPM_TEST_AXI_STREAM_RX_tdata,
    input  logic                         BPM_TEST_AXI_STREAM_RX_tvalid,
    input  logic                         BPM_TEST_AXI_STREAM_RX_tlast,
    output logic                         packetStrobe,
    output logic [INDEX_WIDTH-1:0]       packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0] packetData,
    output logic                         statusStrobe,
    output logic [1:0]                   statusCode,
    output logic [COUNT_WIDTH-1:0]       packetsLastCycle,
    output logic [15:0]                  errorCount
);

    localparam int WCNT_W = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_DATA_WORDS - 1);

    localparam logic [1:0] CODE_OK    = 2'd0;
    localparam logic [1:0] CODE_MAGIC = 2'd1;
    localparam logic [1:0] CODE_SHORT = 2'd2;
    localparam logic [1:0] CODE_LONG  = 2'd3;

    typedef enum logic [1:0] {
        S_HEADER,
        S_DATA,
        S_DISCARD
    } state_t;

    state_t                  state_reg, state_next;
    logic [WCNT_W-1:0]       word_cnt_reg, word_cnt_next;
    logic [INDEX_WIDTH-1:0]  shadow_index_reg;
    logic [31:0]             shadow_data_reg [NUM_DATA_WORDS];
    logic [COUNT_WIDTH-1:0]  cycle_cnt_reg;

    logic [MAGIC_WIDTH-1:0]       hdr_magic;
    logic [INDEX_WIDTH-1:0]       hdr_index;
    logic [32*NUM_DATA_WORDS-1:0] capture_data;

    logic       store_index;
    logic       store_word;
    logic       pkt_good;
    logic       status_valid;
    logic [1:0] status_code_next;

    assign hdr_magic = BPM_TEST_AXI_STREAM_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH];
    assign hdr_index = BPM_TEST_AXI_STREAM_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];

    // The final data word is still on the bus when the packet completes, so it
    // is taken straight from tdata; earlier words come from the shadow slots.
    generate
        for (genvar gi = 0; gi < NUM_DATA_WORDS; gi++) begin : g_capture
            if (gi == NUM_DATA_WORDS - 1) begin : g_last
                assign capture_data[32*gi +: 32] = BPM_TEST_AXI_STREAM_RX_tdata;
            end else begin : g_shadow
                assign capture_data[32*gi +: 32] = shadow_data_reg[gi];
            end
        end
    endgenerate

    // FSM state and word counter registers.
    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            state_reg    <= S_HEADER;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    // Next-state logic and per-beat decisions; a dropped channel abandons any
    // partial packet without reporting it.
    always_comb begin
        state_next       = state_reg;
        word_cnt_next    = word_cnt_reg;
        store_index      = 1'b0;
        store_word       = 1'b0;
        pkt_good         = 1'b0;
        status_valid     = 1'b0;
        status_code_next = CODE_OK;
        if (!auroraChannelUp) begin
            state_next    = S_HEADER;
            word_cnt_next = '0;
        end else if (BPM_TEST_AXI_STREAM_RX_tvalid) begin
            case (state_reg)
                S_HEADER: begin
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        status_valid     = 1'b1;
                        status_code_next = CODE_SHORT;
                    end else if (hdr_magic != EXPECTED_MAGIC) begin
                        status_valid     = 1'b1;
                        status_code_next = CODE_MAGIC;
                        state_next       = S_DISCARD;
                    end else begin
                        store_index   = 1'b1;
                        word_cnt_next = '0;
                        state_next    = S_DATA;
                    end
                end
                S_DATA: begin
                    store_word = 1'b1;
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        status_valid = 1'b1;
                        state_next   = S_HEADER;
                        if (word_cnt_reg == LAST_WORD) begin
                            pkt_good         = 1'b1;
                            status_code_next = CODE_OK;
                        end else begin
                            status_code_next = CODE_SHORT;
                        end
                    end else if (word_cnt_reg == LAST_WORD) begin
                        status_valid     = 1'b1;
                        status_code_next = CODE_LONG;
                        state_next       = S_DISCARD;
                    end else begin
                        word_cnt_next = word_cnt_reg + WCNT_W'(1);
                    end
                end
                S_DISCARD: begin
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        state_next = S_HEADER;
                    end
                end
                default: state_next = S_HEADER;
            endcase
        end
    end

    // Shadow copy of the packet being assembled.
    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            shadow_index_reg <= '0;
            for (int i = 0; i < NUM_DATA_WORDS; i++) begin
                shadow_data_reg[i] <= '0;
            end
        end else begin
            if (store_index) begin
                shadow_index_reg <= hdr_index;
            end
            if (store_word) begin
                shadow_data_reg[word_cnt_reg] <= BPM_TEST_AXI_STREAM_RX_tdata;
            end
        end
    end

    // Publish good packets and status events one cycle after the deciding beat.
    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            packetStrobe <= 1'b0;
            packetIndex  <= '0;
            packetData   <= '0;
            statusStrobe <= 1'b0;
            statusCode   <= CODE_OK;
        end else begin
            packetStrobe <= pkt_good;
            statusStrobe <= status_valid;
            if (pkt_good) begin
                packetIndex <= shadow_index_reg;
                packetData  <= capture_data;
            end
            if (status_valid) begin
                statusCode <= status_code_next;
            end
        end
    end

    // Good-packet count per FA cycle; a completion on the strobe cycle belongs
    // to the new cycle.
    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            cycle_cnt_reg    <= '0;
            packetsLastCycle <= '0;
        end else if (auroraFAstrobe) begin
            packetsLastCycle <= cycle_cnt_reg;
            cycle_cnt_reg    <= pkt_good ? COUNT_WIDTH'(1) : '0;
        end else if (pkt_good && (cycle_cnt_reg != '1)) begin
            cycle_cnt_reg <= cycle_cnt_reg + COUNT_WIDTH'(1);
        end
    end

    // Saturating count of every non-OK status event.
    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            errorCount <= '0;
        end else if (status_valid && (status_code_next != CODE_OK) &&
                     (errorCount != 16'hFFFF)) begin
            errorCount <= errorCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Directed bench for read_bpm_test_link: a beat table for the main packet
// shapes, then hand-written sequences for FA counting, gaps, channel drop
// and asynchronous reset.
module tb_read_bpm_test_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chan_up;
    logic        fa_strobe;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        packet_strobe;
    logic [4:0]  packet_index;
    logic [95:0] packet_data;
    logic        status_strobe;
    logic [1:0]  status_code;
    logic [7:0]  packets_last_cycle;
    logic [15:0] error_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        ep;
        logic        es;
        logic [1:0]  ec;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    read_bpm_test_link dut (
        .auroraUserClk                 (clk),
        .auroraResetN                  (rst_n),
        .auroraChannelUp               (chan_up),
        .auroraFAstrobe                (fa_strobe),
        .BPM_TEST_AXI_STREAM_RX_tdata  (tdata),
        .BPM_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .BPM_TEST_AXI_STREAM_RX_tlast  (tlast),
        .packetStrobe                  (packet_strobe),
        .packetIndex                   (packet_index),
        .packetData                    (packet_data),
        .statusStrobe                  (status_strobe),
        .statusCode                    (status_code),
        .packetsLastCycle              (packets_last_cycle),
        .errorCount                    (error_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Present one bus cycle, let the DUT sample it, return 1 ns after the edge.
    task automatic beat(input logic v, input logic [31:0] d, input logic l);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic l,
                       input logic ep, input logic es, input logic [1:0] ec);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.ep = ep; e.es = es; e.ec = ec;
        tbl.push_back(e);
    endtask

    task automatic good_packet(input logic [4:0] idx, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2,
                               input logic fa_on_last);
        beat(1'b1, 32'hA5BE_0000 | (32'(idx) << 10), 1'b0);
        beat(1'b1, w0, 1'b0);
        beat(1'b1, w1, 1'b0);
        fa_strobe = fa_on_last;
        beat(1'b1, w2, 1'b1);
        fa_strobe = 1'b0;
    endtask

    initial begin
        logic [95:0] exp_data;
        logic [31:0] w [3];
        int          stray;

        rst_n = 1'b0; chan_up = 1'b1; fa_strobe = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pkt_strobe", 128'(packet_strobe), 128'(0));
        check("reset stat_strobe", 128'(status_strobe), 128'(0));
        check("reset index", 128'(packet_index), 128'(0));
        check("reset data", 128'(packet_data), 128'(0));
        check("reset errors", 128'(error_count), 128'(0));
        check("reset last_cycle", 128'(packets_last_cycle), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // good packet, index 3
        add(1, 32'hA5BE_0C00, 0, 0, 0, 0);
        add(1, 32'h1111_1111, 0, 0, 0, 0);
        add(1, 32'h2222_2222, 0, 0, 0, 0);
        add(1, 32'h3333_3333, 1, 1, 1, 0);
        // bad magic: reported on the header, rest discarded
        add(1, 32'h1234_0400, 0, 0, 1, 1);
        add(1, 32'hDEAD_0001, 0, 0, 0, 0);
        add(1, 32'hDEAD_0002, 0, 0, 0, 0);
        add(1, 32'hDEAD_0003, 1, 0, 0, 0);
        // good packet, index 5
        add(1, 32'hA5BE_1400, 0, 0, 0, 0);
        add(1, 32'hAAAA_AAAA, 0, 0, 0, 0);
        add(1, 32'hBBBB_BBBB, 0, 0, 0, 0);
        add(1, 32'hCCCC_CCCC, 1, 1, 1, 0);
        // short packet: tlast on second data word
        add(1, 32'hA5BE_0800, 0, 0, 0, 0);
        add(1, 32'h4444_4444, 0, 0, 0, 0);
        add(1, 32'h5555_5555, 1, 0, 1, 2);
        // header-only packet
        add(1, 32'hA5BE_0000, 1, 0, 1, 2);
        // long packet: code 3 on third data word, then discard to tlast
        add(1, 32'hA5BE_0400, 0, 0, 0, 0);
        add(1, 32'h6666_6666, 0, 0, 0, 0);
        add(1, 32'h7777_7777, 0, 0, 0, 0);
        add(1, 32'h8888_8888, 0, 0, 1, 3);
        add(1, 32'h9999_9999, 0, 0, 0, 0);
        add(1, 32'h1234_5678, 1, 0, 0, 0);
        // good packet with ignored header bits set and tvalid gaps (index 3)
        add(1, 32'hA5BE_8FFF, 0, 0, 0, 0);
        add(0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        add(1, 32'h0101_0101, 0, 0, 0, 0);
        add(0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        add(0, 32'h0000_0000, 0, 0, 0, 0);
        add(1, 32'h0202_0202, 0, 0, 0, 0);
        add(1, 32'h0303_0303, 1, 1, 1, 0);
        // good packet, index 7
        add(1, 32'hA5BE_1C00, 0, 0, 0, 0);
        add(1, 32'h0A0A_0A0A, 0, 0, 0, 0);
        add(1, 32'h0B0B_0B0B, 0, 0, 0, 0);
        add(1, 32'h0C0C_0C0C, 1, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].v, tbl[i].d, tbl[i].l);
            check($sformatf("vec%0d pkt_strobe", i), 128'(packet_strobe), 128'(tbl[i].ep));
            check($sformatf("vec%0d stat_strobe", i), 128'(status_strobe), 128'(tbl[i].es));
            if (tbl[i].es) begin
                check($sformatf("vec%0d code", i), 128'(status_code), 128'(tbl[i].ec));
            end
            if (i == 3) begin
                check("first index", 128'(packet_index), 128'(3));
                check("first data", 128'(packet_data), 128'(96'h33333333_22222222_11111111));
            end
            if (i == 28) begin
                check("gap index", 128'(packet_index), 128'(3));
                check("gap data", 128'(packet_data), 128'(96'h03030303_02020202_01010101));
            end
        end
        check("table index", 128'(packet_index), 128'(7));
        check("table data", 128'(packet_data), 128'(96'h0C0C0C0C_0B0B0B0B_0A0A0A0A));
        check("table errors", 128'(error_count), 128'(4));

        // four good packets so far, then an FA strobe
        fa_strobe = 1'b1;
        @(posedge clk);
        #1;
        fa_strobe = 1'b0;
        check("fa count 4", 128'(packets_last_cycle), 128'(4));

        // short packet leaves packetData untouched
        beat(1'b1, 32'hA5BE_0800, 1'b0);
        beat(1'b1, 32'hEEEE_EEEE, 1'b1);
        check("short code", 128'(status_code), 128'(2));
        check("short keeps data", 128'(packet_data), 128'(96'h0C0C0C0C_0B0B0B0B_0A0A0A0A));
        check("short errors", 128'(error_count), 128'(5));

        // completion coincident with FA strobe goes to the new cycle
        good_packet(5'd1, 32'h0000_0011, 32'h0000_0012, 32'h0000_0013, 1'b0);
        good_packet(5'd2, 32'h0000_0021, 32'h0000_0022, 32'h0000_0023, 1'b1);
        check("coinc strobe", 128'(packet_strobe), 128'(1));
        check("coinc last_cycle", 128'(packets_last_cycle), 128'(1));
        fa_strobe = 1'b1;
        @(posedge clk);
        #1;
        fa_strobe = 1'b0;
        check("coinc next fa", 128'(packets_last_cycle), 128'(1));

        // random tvalid gaps
        for (int p = 0; p < 4; p++) begin
            stray = 0;
            for (int k = 0; k < 3; k++) w[k] = 32'h1000_0000 * (k + 1) + 32'(p);
            exp_data = {w[2], w[1], w[0]};
            beat(1'b1, 32'hA5BE_0000 | (32'(p + 10) << 10), 1'b0);
            for (int k = 0; k < 3; k++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    beat(1'b0, 32'hFFFF_FFFF, 1'b1);
                    if (packet_strobe || status_strobe) stray++;
                end
                beat(1'b1, w[k], k == 2);
                if (k < 2 && (packet_strobe || status_strobe)) stray++;
            end
            check($sformatf("gap%0d strobe", p), 128'(packet_strobe), 128'(1));
            check($sformatf("gap%0d index", p), 128'(packet_index), 128'(p + 10));
            check($sformatf("gap%0d data", p), 128'(packet_data), 128'(exp_data));
            check($sformatf("gap%0d stray", p), 128'(stray), 128'(0));
        end

        // channel drop after the header: partial packet dropped silently
        beat(1'b1, 32'hA5BE_1800, 1'b0);
        beat(1'b1, 32'h0000_00E1, 1'b0);
        chan_up = 1'b0;
        beat(1'b1, 32'h0000_00E2, 1'b1);
        check("drop pkt_strobe", 128'(packet_strobe), 128'(0));
        check("drop stat_strobe", 128'(status_strobe), 128'(0));
        chan_up = 1'b1;
        @(posedge clk);
        #1;
        check("drop idle strobe", 128'(status_strobe), 128'(0));
        good_packet(5'd1, 32'h0000_00F1, 32'h0000_00F2, 32'h0000_00F3, 1'b0);
        check("fresh strobe", 128'(packet_strobe), 128'(1));
        check("fresh index", 128'(packet_index), 128'(1));
        check("fresh data", 128'(packet_data), 128'(96'h000000F3_000000F2_000000F1));
        check("fresh errors", 128'(error_count), 128'(5));

        // asynchronous reset mid-packet
        beat(1'b1, 32'hA5BE_0400, 1'b0);
        beat(1'b1, 32'h5A5A_5A5A, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async index", 128'(packet_index), 128'(0));
        check("async data", 128'(packet_data), 128'(0));
        check("async errors", 128'(error_count), 128'(0));
        check("async last_cycle", 128'(packets_last_cycle), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        good_packet(5'd9, 32'h0000_0091, 32'h0000_0092, 32'h0000_0093, 1'b0);
        check("post-reset index", 128'(packet_index), 128'(9));
        check("post-reset data", 128'(packet_data), 128'(96'h00000093_00000092_00000091));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
